// File: rtl/uart_rx_fifo.sv
// UART receiver with input synchroniser, 3-sample majority vote, parity/framing/break
// detection and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLOCKS_PER_BIT = 40,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          uart_data,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(CLOCKS_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_VOTE = CW'(CLOCKS_PER_BIT / 2 + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  typedef struct packed {
    logic                 perr;
    logic                 ferr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q;
  logic line_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_data;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 brk_q, brk_d;

  logic   vote;
  logic   at_vote;
  logic   bit_end;
  logic   push;
  entry_t push_entry;

  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & line_s) | (smp_q[1] & line_s);
  assign at_vote = (cnt_q == SMP_VOTE);
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      smp_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      smp_q      <= smp_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_bit_q  <= par_bit_d;
      brk_q      <= brk_d;
    end
  end

  // NOTE: combinational logic uses blocking '=' and assigns every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CW'(1);
    smp_d      = smp_q;
    data_d     = data_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    brk_d      = 1'b0;
    push       = 1'b0;
    push_entry = '{perr: perr_q, ferr: ferr_q | ~vote, data: data_q};

    if (cnt_q == SMP_A) smp_d[0] = line_s;
    if (cnt_q == SMP_B) smp_d[1] = line_s;

    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        par_bit_d  = 1'b0;
        if (!line_s) state_d = S_START;
      end

      S_START: begin
        if (at_vote && vote) state_d = S_IDLE;
        else if (bit_end)    state_d = S_DATA;
      end

      S_DATA: begin
        if (at_vote) begin
          data_d = {vote, data_q[DATA_BITS-1:1]};
          idx_d  = idx_q + IW'(1);
        end
        if (bit_end && idx_q == IDX_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end

      S_PARITY: begin
        if (at_vote) begin
          par_bit_d = vote;
          perr_d    = ((^data_q) ^ vote) != PAR_ODD;
        end
        if (bit_end) state_d = S_STOP;
      end

      S_STOP: begin
        if (at_vote) begin
          if (!vote) ferr_d = 1'b1;
          // A low line through data, parity and stop is a break, not a character.
          if (stop_idx_q == STOP_LAST) begin
            if ((ferr_q || !vote) && data_q == '0 && !par_bit_q) begin
              brk_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_BREAK;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        if (bit_end) stop_idx_d = 1'b1;
      end

      S_BREAK: begin
        if (!line_s)      cnt_d   = '0;
        else if (bit_end) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ovr_d;

  logic   full;
  logic   pop;
  logic   wr_en;
  entry_t head;

  assign full  = (count_q == CNT_FULL);
  assign pop   = rx_valid & rx_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = push & full & ~pop;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the outputs are gated by rx_valid,
  // so stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign rx_valid      = (count_q != '0);
  assign rx_data       = rx_valid ? head.data : '0;
  assign rx_parity_err = rx_valid & head.perr;
  assign rx_frame_err  = rx_valid & head.ferr;
  assign overrun       = ovr_q;
  assign break_det     = brk_q;
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance, table-driven frames,
// break/overrun/glitch/reset sequences and a randomized run against a frame-level model.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  typedef struct {
    int         which;   // 0 = 8N1 instance, 1 = 8E2 instance
    logic [7:0] d;
    logic       pbit;
    logic [1:0] stops;   // bit0 = first stop bit
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_a = 1'b1, uart_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       pe_a, pe_b, fe_a, fe_b, valid_a, valid_b;
  logic       ovr_a, ovr_b, brk_a, brk_b;
  logic [2:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  // monitor-owned capture state
  ent_t got_a [256];
  ent_t got_b [256];
  int   n_a = 0, n_b = 0, vc_a = 0, vc_b = 0;
  int   ov_a = 0, ov_b = 0, bk_a = 0, bk_b = 0;

  bit   done;
  vec_t vecs [10];
  ent_t exp_q [$];

  always #5 clock = ~clock;

  uart_rx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut_a (
    .clock(clock), .reset(reset), .uart_data(uart_a),
    .rx_data(data_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .overrun(ovr_a), .break_det(brk_a), .fifo_count(cnt_a)
  );

  uart_rx_fifo #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH)) dut_b (
    .clock(clock), .reset(reset), .uart_data(uart_b),
    .rx_data(data_b), .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .overrun(ovr_b), .break_det(brk_b), .fifo_count(cnt_b)
  );

  always @(negedge clock) begin
    if (valid_a === 1'b1 && ready_a === 1'b1) begin
      got_a[n_a % 256] <= {data_a, pe_a, fe_a};
      n_a <= n_a + 1;
    end
    if (valid_b === 1'b1 && ready_b === 1'b1) begin
      got_b[n_b % 256] <= {data_b, pe_b, fe_b};
      n_b <= n_b + 1;
    end
    if (valid_a === 1'b1) vc_a <= vc_a + 1;
    if (valid_b === 1'b1) vc_b <= vc_b + 1;
    if (ovr_a === 1'b1)   ov_a <= ov_a + 1;
    if (ovr_b === 1'b1)   ov_b <= ov_b + 1;
    if (brk_a === 1'b1)   bk_a <= bk_a + 1;
    if (brk_b === 1'b1)   bk_b <= bk_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) uart_a = v;
    else            uart_b = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops);
    logic [11:0] bits;
    int          nb;
    if (which == 0) begin
      bits = {2'b11, stops[0], d, 1'b0};
      nb   = 10;
    end else begin
      bits = {stops[1], stops[0], pbit, d, 1'b0};
      nb   = 12;
    end
    for (int i = 0; i < nb; i++) drive(which, bits[i], CPB);
  endtask

  task automatic expect_entry(input string name, input ent_t e, input logic [7:0] d,
                              input logic pe, input logic fe);
    check({name, "_data"}, 32'(e.d), 32'(d));
    check({name, "_perr"}, 32'(e.pe), 32'(pe));
    check({name, "_ferr"}, 32'(e.fe), 32'(fe));
  endtask

  initial begin
    int   n0, v0, o0, b0, nb0, bb0, exp_brk;
    ent_t e;
    vec_t v;

    vecs[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h55, 1'b0, 2'b10, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{0, 8'h12, 1'b0, 2'b11, 8'h12, 1'b0, 1'b0};
    vecs[5] = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1, 8'h80, 1'b1, 2'b10, 8'h80, 1'b0, 1'b1};
    vecs[8] = '{1, 8'h01, 1'b0, 2'b11, 8'h01, 1'b1, 1'b0};
    vecs[9] = '{1, 8'h7E, 1'b0, 2'b01, 8'h7E, 1'b0, 1'b1};

    // reset state
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("rst_valid_a", 32'(valid_a), 0);
    check("rst_data_a",  32'(data_a), 0);
    check("rst_count_a", 32'(cnt_a), 0);
    check("rst_flags_a", 32'({pe_a, fe_a, ovr_a, brk_a}), 0);
    check("rst_valid_b", 32'(valid_b), 0);
    reset = 1'b0;
    drive(0, 1'b1, 4);

    // table-driven single frames
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v  = vecs[i];
      n0 = (v.which == 0) ? n_a : n_b;
      v0 = (v.which == 0) ? vc_a : vc_b;
      send_frame(v.which, v.d, v.pbit, v.stops);
      drive(v.which, 1'b1, 2 * CPB);
      check($sformatf("v%0d_entries", i), 32'(((v.which == 0) ? n_a : n_b) - n0), 1);
      check($sformatf("v%0d_valid_cycles", i), 32'(((v.which == 0) ? vc_a : vc_b) - v0), 1);
      check($sformatf("v%0d_count", i), 32'((v.which == 0) ? cnt_a : cnt_b), 0);
      e = (v.which == 0) ? got_a[n0 % 256] : got_b[n0 % 256];
      expect_entry($sformatf("v%0d", i), e, v.exp_d, v.exp_pe, v.exp_fe);
    end

    // break: line low for 20 bit times, then idle, then a normal frame
    n0 = n_a;
    b0 = bk_a;
    drive(0, 1'b0, 20 * CPB);
    check("brk_count_low", 32'(cnt_a), 0);
    drive(0, 1'b1, 3 * CPB);
    check("brk_pulses", 32'(bk_a - b0), 1);
    check("brk_no_entry", 32'(n_a - n0), 0);
    send_frame(0, 8'h81, 1'b0, 2'b11);
    drive(0, 1'b1, 2 * CPB);
    check("brk_next_entries", 32'(n_a - n0), 1);
    expect_entry("brk_next", got_a[n0 % 256], 8'h81, 1'b0, 1'b0);

    // overrun: five back-to-back frames into a four-deep FIFO with no consumer
    ready_a = 1'b0;
    n0 = n_a;
    o0 = ov_a;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
    drive(0, 1'b1, 2 * CPB);
    check("ovr_count", 32'(cnt_a), DEPTH);
    check("ovr_valid", 32'(valid_a), 1);
    check("ovr_head", 32'(data_a), 32'h01);
    check("ovr_pulses", 32'(ov_a - o0), 1);
    ready_a = 1'b1;
    drive(0, 1'b1, 10);
    check("ovr_popped", 32'(n_a - n0), 4);
    for (int i = 0; i < 4; i++)
      expect_entry($sformatf("ovr_pop%0d", i), got_a[(n0 + i) % 256], 8'(i + 1), 1'b0, 1'b0);
    check("ovr_drained", 32'(cnt_a), 0);

    // randomized frames on the parity/two-stop instance against a frame-level model
    nb0     = n_b;
    bb0     = bk_b;
    exp_brk = 0;
    done    = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] d;
          logic       pbit, pe, fe;
          logic [1:0] st;
          d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          pbit = (^d) ^ ($urandom_range(0, 3) == 0);
          st   = {1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0)};
          pe   = (pbit != (^d));
          fe   = (st != 2'b11);
          if (fe && d == 8'h00 && !pbit) exp_brk++;
          else exp_q.push_back('{d: d, pe: pe, fe: fe});
          send_frame(1, d, pbit, st);
          drive(1, 1'b1, 2 * CPB);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready_b = 1'($urandom_range(0, 1));
          @(posedge clock);
          #1;
        end
      end
    join
    ready_b = 1'b1;
    drive(1, 1'b1, 40);
    check("rnd_entries", 32'(n_b - nb0), 32'(exp_q.size()));
    check("rnd_breaks", 32'(bk_b - bb0), 32'(exp_brk));
    for (int i = 0; i < exp_q.size(); i++)
      expect_entry($sformatf("rnd%0d", i), got_b[(nb0 + i) % 256],
                   exp_q[i].d, exp_q[i].pe, exp_q[i].fe);

    // short low glitch is rejected as a false start
    n0 = n_a;
    b0 = bk_a;
    drive(0, 1'b0, CPB / 4);
    drive(0, 1'b1, 3 * CPB);
    check("glitch_entries", 32'(n_a - n0), 0);
    check("glitch_breaks", 32'(bk_a - b0), 0);
    check("glitch_valid", 32'(valid_a), 0);

    // reset in the middle of a data bit with one entry already buffered
    ready_a = 1'b0;
    send_frame(0, 8'h33, 1'b0, 2'b11);
    drive(0, 1'b1, 2 * CPB);
    check("prerst_count", 32'(cnt_a), 1);
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, CPB);
    drive(0, 1'b0, CPB / 2);
    reset = 1'b1;
    drive(0, 1'b1, 3);
    check("midrst_valid", 32'(valid_a), 0);
    check("midrst_data", 32'(data_a), 0);
    check("midrst_count", 32'(cnt_a), 0);
    check("midrst_flags", 32'({pe_a, fe_a, ovr_a, brk_a}), 0);
    reset = 1'b0;
    drive(0, 1'b1, 2 * CPB);
    ready_a = 1'b1;
    n0 = n_a;
    send_frame(0, 8'hF0, 1'b0, 2'b11);
    drive(0, 1'b1, 2 * CPB);
    check("postrst_entries", 32'(n_a - n0), 1);
    expect_entry("postrst", got_a[n0 % 256], 8'hF0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
